// File: rtl/counter_monitor.sv
// Tracks the +1 mod 4 sequence of a 2-bit free-running counter, pulses and counts wraps (3->0).
// Optional sequence checker enabled by defining SEQ_CHECK_EN.
module counter_monitor #(
    parameter int unsigned WRAP_W    = 8,
    parameter bit          WRAP_SAT  = 1'b1,
    parameter int unsigned ERR_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [1:0]        val,
    output logic              wrap,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              locked,
    output logic              err,
    output logic [3:0]        err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_TRACK
    } state_t;

    if (ERR_LIMIT < 1 || ERR_LIMIT > 15) begin : g_bad_limit
        $error("counter_monitor: ERR_LIMIT must be in 1..15");
    end

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_prev;
    logic              r_wrap;
    logic [WRAP_W-1:0] r_wrap_cnt;
    logic              r_locked;

    logic [1:0]        w_prev_inc;
    logic              w_step_ok;
    logic              w_track;
    logic              w_wrap;
    logic              w_resync;

    assign w_prev_inc = r_prev + 2'd1;
    assign w_step_ok  = (val == w_prev_inc);
    assign w_track    = en && (r_state == ST_TRACK);
    assign w_wrap     = w_track && (r_prev == 2'd3) && (val == 2'd0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (en) w_next = ST_SYNC;
            ST_SYNC:  w_next = en ? ST_TRACK : ST_IDLE;
            ST_TRACK: begin
                if (!en)          w_next = ST_IDLE;
                else if (w_resync) w_next = ST_SYNC;
            end
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_prev     <= '0;
            r_wrap     <= 1'b0;
            r_wrap_cnt <= '0;
            r_locked   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_locked <= (w_next == ST_TRACK);
            r_wrap   <= w_wrap;
            if (en && r_state != ST_IDLE)
                r_prev <= val;
            // clr overrides a coincident wrap; the wrap pulse itself is still emitted
            if (clr)
                r_wrap_cnt <= '0;
            else if (w_wrap && !(WRAP_SAT && (&r_wrap_cnt)))
                r_wrap_cnt <= r_wrap_cnt + 1'b1;
        end
    end

`ifdef SEQ_CHECK_EN
    logic [3:0] r_bad;
    logic       r_err;
    logic [3:0] r_err_cnt;
    logic       w_bad_step;

    assign w_bad_step = w_track && !w_step_ok;
    assign w_resync   = w_bad_step && (({1'b0, r_bad} + 5'd1) >= 5'(ERR_LIMIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bad     <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (r_state == ST_SYNC)
                r_bad <= '0;
            else if (w_track)
                r_bad <= w_step_ok ? 4'd0 : r_bad + 4'd1;
            if (clr) begin
                r_err     <= 1'b0;
                r_err_cnt <= '0;
            end else if (w_bad_step) begin
                r_err <= 1'b1;
                if (r_err_cnt != 4'd15)
                    r_err_cnt <= r_err_cnt + 4'd1;
            end
        end
    end

    assign err     = r_err;
    assign err_cnt = r_err_cnt;
`else
    assign w_resync = 1'b0;
    assign err      = 1'b0;
    assign err_cnt  = '0;
`endif

    assign wrap     = r_wrap;
    assign wrap_cnt = r_wrap_cnt;
    assign locked   = r_locked;

endmodule

// File: tb/tb_counter_monitor.sv
// Directed bench for counter_monitor: default config plus two narrow wrap counters (saturating / wrapping).
// Checker expectations follow SEQ_CHECK_EN when the macro is defined.
module tb_counter_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       clr;
    logic [1:0] val;

    logic       d_wrap,  s_wrap,  w_wrap;
    logic [7:0] d_cnt;
    logic [1:0] s_cnt,   w_cnt;
    logic       d_lock,  s_lock,  w_lock;
    logic       d_err,   s_err,   w_err;
    logic [3:0] d_ecnt,  s_ecnt,  w_ecnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    counter_monitor #(.WRAP_W(8), .WRAP_SAT(1'b1), .ERR_LIMIT(3)) u_dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .val(val),
        .wrap(d_wrap), .wrap_cnt(d_cnt), .locked(d_lock), .err(d_err), .err_cnt(d_ecnt)
    );

    counter_monitor #(.WRAP_W(2), .WRAP_SAT(1'b1), .ERR_LIMIT(3)) u_w2s (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .val(val),
        .wrap(s_wrap), .wrap_cnt(s_cnt), .locked(s_lock), .err(s_err), .err_cnt(s_ecnt)
    );

    counter_monitor #(.WRAP_W(2), .WRAP_SAT(1'b0), .ERR_LIMIT(3)) u_w2w (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .val(val),
        .wrap(w_wrap), .wrap_cnt(w_cnt), .locked(w_lock), .err(w_err), .err_cnt(w_ecnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // drive val, let one rising edge pass, return 1 time unit later
    task automatic step(input logic [1:0] v);
        val = v;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_d_wrap"}, 32'(d_wrap), 0);
        chk({tag, "_d_cnt"},  32'(d_cnt),  0);
        chk({tag, "_d_lock"}, 32'(d_lock), 0);
        chk({tag, "_d_err"},  32'(d_err),  0);
        chk({tag, "_d_ecnt"}, 32'(d_ecnt), 0);
        chk({tag, "_s_all"},  32'({s_wrap, s_cnt, s_lock, s_err, s_ecnt}), 0);
        chk({tag, "_w_all"},  32'({w_wrap, w_cnt, w_lock, w_err, w_ecnt}), 0);
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b0;
        clr = 1'b0;
        val = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b1;
        en  = 1'b1;

        step(2'd0);
        chk("sync_lock", 32'(d_lock), 0);
        step(2'd1);
        chk("track_lock", 32'(d_lock), 1);
        chk("track_wrap", 32'(d_wrap), 0);
        step(2'd2);
        step(2'd3);
        chk("pre_wrap", 32'(d_wrap), 0);
        step(2'd0);
        chk("wrap1",     32'(d_wrap), 1);
        chk("wrap1_cnt", 32'(d_cnt),  1);
        step(2'd1);
        chk("wrap1_end", 32'(d_wrap), 0);

        for (int k = 2; k <= 5; k++) begin
            step(2'd2);
            step(2'd3);
            step(2'd0);
            chk("wrapk",       32'(d_wrap), 1);
            chk("wrapk_cnt",   32'(d_cnt),  32'(k));
            chk("sat_wrap",    32'(s_wrap), 1);
            chk("sat_cnt",     32'(s_cnt),  32'((k > 3) ? 3 : k));
            chk("roll_cnt",    32'(w_cnt),  32'(k % 4));
            step(2'd1);
            chk("wrapk_end",   32'(d_wrap), 0);
        end

        step(2'd2);
        step(2'd3);
        clr = 1'b1;
        step(2'd0);
        clr = 1'b0;
        chk("clr_wrap", 32'(d_wrap), 1);
        chk("clr_cnt",  32'(d_cnt),  0);
        chk("clr_scnt", 32'(s_cnt),  0);
        step(2'd1);
        chk("clr_after", 32'(d_wrap), 0);

        step(2'd3);
`ifdef SEQ_CHECK_EN
        chk("bad1_err",  32'(d_err),  1);
        chk("bad1_ecnt", 32'(d_ecnt), 1);
`else
        chk("bad1_err",  32'(d_err),  0);
        chk("bad1_ecnt", 32'(d_ecnt), 0);
`endif
        chk("bad1_lock", 32'(d_lock), 1);
        step(2'd0);
        chk("bad1_wrap", 32'(d_wrap), 1);
        chk("bad1_cnt",  32'(d_cnt),  1);
        step(2'd1);
        clr = 1'b1;
        step(2'd2);
        clr = 1'b0;
        chk("clr2_cnt", 32'(d_cnt), 0);
        step(2'd2);
        step(2'd2);
        chk("hold2_lock", 32'(d_lock), 1);
        step(2'd2);
`ifdef SEQ_CHECK_EN
        chk("hold_ecnt", 32'(d_ecnt), 3);
        chk("hold_err",  32'(d_err),  1);
        chk("hold_lock", 32'(d_lock), 0);
`else
        chk("hold_ecnt", 32'(d_ecnt), 0);
        chk("hold_err",  32'(d_err),  0);
        chk("hold_lock", 32'(d_lock), 1);
`endif
        step(2'd3);
        chk("relock", 32'(d_lock), 1);
        step(2'd0);
        chk("relock_wrap", 32'(d_wrap), 1);
        chk("relock_cnt",  32'(d_cnt),  1);

        en = 1'b0;
        step(2'd1);
        chk("dis_lock", 32'(d_lock), 0);
        chk("dis_cnt",  32'(d_cnt),  1);
        step(2'd2);
        chk("idle_lock", 32'(d_lock), 0);
        en = 1'b1;
        step(2'd3);
        chk("reen_sync", 32'(d_lock), 0);
        step(2'd0);
        chk("reen_lock", 32'(d_lock), 1);
        chk("reen_nowrap", 32'(d_wrap), 0);
        chk("reen_cnt", 32'(d_cnt), 1);
        step(2'd1);
        step(2'd2);
        step(2'd3);
        step(2'd0);
        chk("reen_wrap", 32'(d_wrap), 1);
        chk("reen_cnt2", 32'(d_cnt),  2);

        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("async");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
